jt49_bus_master: RTL and testbench
==================================

// Module: jt49_bus_master
// PURPOSE
//  CPU-side initiator for the AY-3-8910 BDIR/BC1 bus. Turns single register
//  write/read requests (valid/ready) into the latch-address -> inactive ->
//  write/read -> inactive pin sequence that the chip-side bus wrapper decodes.
//  Sits between a soft-CPU/sequencer and a jt49 bus instance in sound cores.
// PARAMETERS
//  HOLD  2  cycles each active phase (ADDR, WR, RD) is held; legal 2..15
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  rst_n      in   1  asynchronous, active-low reset
//  req_valid  in   1  request present
//  req_ready  out  1  request accepted when req_valid && req_ready at posedge
//  req_rd     in   1  1 = register read, 0 = register write
//  req_addr   in   4  PSG register number 0..15
//  req_data   in   8  write data (ignored for reads)
//  rsp_valid  out  1  one-cycle pulse, read data valid
//  rsp_data   out  8  read data, held until next read completes
//  bdir       out  1  to chip BDIR
//  bc1        out  1  to chip BC1
//  bus_dout   out  8  to chip data-in
//  bus_din    in   8  from chip data-out
//  busy       out  1  ~req_ready
// BEHAVIOUR
//  - Reset (async, immediate): bdir=0 bc1=0 bus_dout=0 req_ready=1 rsp_valid=0
//    rsp_data=0 busy=0; FSM->IDLE; in-flight transaction dropped, no rsp.
//  - All outputs registered. FSM: IDLE, ADDR, GAP1, XFER, GAP2.
//  - IDLE: req_ready=1, {bdir,bc1}=00. On accept: capture rd/addr/data,
//    req_ready=0 next cycle, go ADDR.
//  - ADDR: HOLD cycles, {bdir,bc1}=11, bus_dout={4'h0,addr}.
//  - GAP1: 1 cycle, {bdir,bc1}=00, bus_dout unchanged.
//  - XFER write: HOLD cycles, {bdir,bc1}=10, bus_dout=data, stable throughout.
//  - XFER read: HOLD cycles, {bdir,bc1}=01, bus_dout=0; bus_din sampled into
//    rsp_data at last XFER edge.
//  - GAP2: 1 cycle, {bdir,bc1}=00; read: rsp_valid=1 this cycle only.
//    Then IDLE (req_ready=1 next cycle).
//  - Phase counter 4 bits, loads HOLD-1, counts to 0; no wrap.
//  - Latency: accept edge E0; bus busy for 2*HOLD+2 cycles; next accept
//    possible at edge E0+2*HOLD+3. HOLD=2 -> accept every 7 cycles.
//  - Never drive {bdir,bc1} directly between two active codes; GAP always
//    inserted. req_* ignored while not IDLE (no queueing).
//  - req_valid dropped after accept: no effect, transaction completes.
// CONFIGURATION
//  JT49_ADDR_CACHE_EN defined: last latched address kept in a valid+4-bit
//  register; if accepted req_addr equals it and valid, ADDR and GAP1 are
//  skipped (go straight to XFER; busy HOLD+1 cycles). Cache invalidated by
//  reset; set valid on every ADDR phase completion.
//  Not defined: ADDR phase always issued; no cache logic present.
// TESTING
//  1 HOLD=2, write addr=7 data=0x38 -> bdir/bc1 11,11,00,10,10,00; bus_dout
//    0x07 then 0x38; chip reg7=0x38; req_ready back at cycle 7.
//  2 Read addr=0 after writing 0x5A -> bc1-only phase 2 cycles,
//    rsp_valid one pulse, rsp_data=0x5A.
//  3 rst_n low during WR phase -> outputs 00/0 immediately, no rsp_valid,
//    chip register unchanged; next request completes normally.
//  4 Back-to-back writes with req_valid held high -> exactly one accept per
//    7 cycles, never bdir=bc1=1 adjacent to 10/01 without a 00 cycle.
//  5 JT49_ADDR_CACHE_EN: two writes to addr=8 -> second shows no 11 phase,
//    busy 3 cycles; after reset first write to addr=8 has 11 phase again.
//  6 HOLD=15, read addr=15 -> XFER lasts 15 cycles, rsp_data matches chip.

Source files
------------

// File: rtl/jt49_bus_master.sv
// CPU-side initiator for the AY-3-8910 BDIR/BC1 bus: one valid/ready request becomes an
// ADDR -> GAP1 -> XFER -> GAP2 pin sequence. Optional address cache: JT49_ADDR_CACHE_EN.
module jt49_bus_master #(
  parameter int unsigned HOLD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       bdir,
  output logic       bc1,
  output logic [7:0] bus_dout,
  input  logic [7:0] bus_din,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, ADDR, GAP1, XFER, GAP2} state_t;
  localparam logic [3:0] CNT_LD = 4'(HOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rd_q, rd_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       bdir_q, bdir_d, bc1_q, bc1_d;
  logic [7:0] bus_dout_q, bus_dout_d;
  logic       req_ready_q, req_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       busy_q, busy_d;
  logic       skip_addr;

`ifdef JT49_ADDR_CACHE_EN
  logic       cvld_q, cvld_d;
  logic [3:0] caddr_q, caddr_d;
  assign skip_addr = cvld_q && (caddr_q == req_addr);
`else
  assign skip_addr = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    bus_dout_d  = bus_dout_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    bdir_d      = 1'b0;
    bc1_d       = 1'b0;
`ifdef JT49_ADDR_CACHE_EN
    cvld_d      = cvld_q;
    caddr_d     = caddr_q;
`endif
    case (state_q)
      IDLE: if (req_valid && req_ready_q) begin
        rd_d    = req_rd;
        addr_d  = req_addr;
        data_d  = req_data;
        cnt_d   = CNT_LD;
        state_d = skip_addr ? XFER : ADDR;
      end
      ADDR: if (cnt_q == 4'd0) begin
        state_d = GAP1;
`ifdef JT49_ADDR_CACHE_EN
        cvld_d  = 1'b1;
        caddr_d = addr_q;
`endif
      end else cnt_d = cnt_q - 4'd1;
      GAP1: begin
        state_d = XFER;
        cnt_d   = CNT_LD;
      end
      XFER: if (cnt_q == 4'd0) begin
        state_d = GAP2;
        if (rd_q) rsp_data_d = bus_din;
      end else cnt_d = cnt_q - 4'd1;
      GAP2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Pin outputs are registered, so decode them from the state being entered.
    case (state_d)
      ADDR: begin
        bdir_d     = 1'b1;
        bc1_d      = 1'b1;
        bus_dout_d = {4'h0, addr_d};
      end
      XFER: begin
        bdir_d     = ~rd_d;
        bc1_d      = rd_d;
        bus_dout_d = rd_d ? 8'h00 : data_d;
      end
      GAP2:    rsp_valid_d = rd_q;
      default: ;
    endcase
    req_ready_d = (state_d == IDLE);
    busy_d      = ~req_ready_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rd_q        <= 1'b0;
      addr_q      <= 4'd0;
      data_q      <= 8'd0;
      bdir_q      <= 1'b0;
      bc1_q       <= 1'b0;
      bus_dout_q  <= 8'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
      busy_q      <= 1'b0;
`ifdef JT49_ADDR_CACHE_EN
      cvld_q      <= 1'b0;
      caddr_q     <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      bdir_q      <= bdir_d;
      bc1_q       <= bc1_d;
      bus_dout_q  <= bus_dout_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
`ifdef JT49_ADDR_CACHE_EN
      cvld_q      <= cvld_d;
      caddr_q     <= caddr_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign bdir      = bdir_q;
  assign bc1       = bc1_q;
  assign bus_dout  = bus_dout_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_jt49_bus_master.sv
// Directed bench for jt49_bus_master: HOLD=2 instance against a small PSG bus model,
// plus a HOLD=15 instance for the long read case.
module tb_jt49_bus_master;
  logic clk, rst_n;
  logic req_valid, req_ready, req_rd, rsp_valid, bdir, bc1, busy;
  logic [3:0] req_addr;
  logic [7:0] req_data, rsp_data, bus_dout, bus_din;
  logic req_valid2, req_ready2, req_rd2, rsp_valid2, bdir2, bc12, busy2;
  logic [3:0] req_addr2;
  logic [7:0] req_data2, rsp_data2, bus_dout2, bus_din2;

  int n_tests = 0, n_fail = 0;

  jt49_bus_master #(.HOLD(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .bdir(bdir), .bc1(bc1),
    .bus_dout(bus_dout), .bus_din(bus_din), .busy(busy));

  jt49_bus_master #(.HOLD(15)) dut15 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_rd(req_rd2), .req_addr(req_addr2), .req_data(req_data2),
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .bdir(bdir2), .bc1(bc12),
    .bus_dout(bus_dout2), .bus_din(bus_din2), .busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PSG bus model: latch address on 11, commit write when 10 falls to 00 out of reset.
  logic       chip_clr;
  logic [7:0] chip_reg [16];
  logic [3:0] alat, alat2;
  logic [1:0] prev_code;
  logic [7:0] wdat;
  always @(posedge clk) begin
    if (chip_clr) begin
      for (int i = 0; i < 16; i++) chip_reg[i] <= 8'h00;
      prev_code <= 2'b00;
    end else if (!rst_n) prev_code <= 2'b00;
    else begin
      if ({bdir, bc1} == 2'b11) alat <= bus_dout[3:0];
      if ({bdir, bc1} == 2'b10) wdat <= bus_dout;
      if (prev_code == 2'b10 && {bdir, bc1} == 2'b00) chip_reg[alat] <= wdat;
      prev_code <= {bdir, bc1};
    end
  end
  assign bus_din = ({bdir, bc1} == 2'b01) ? chip_reg[alat] : 8'h00;

  always @(posedge clk) if ({bdir2, bc12} == 2'b11) alat2 <= bus_dout2[3:0];
  assign bus_din2 = ({bdir2, bc12} == 2'b01) ? {alat2, ~alat2} : 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [1:0] tr_code [0:40];
  logic [7:0] tr_dout [0:40];
  logic [7:0] tr_rspd [0:40];
  logic       tr_rdy  [0:40];
  logic       tr_rsp  [0:40];
  logic       tr_busy [0:40];

  // Issue one request on the HOLD=2 instance and record ncyc cycles after the accept edge.
  task automatic run_txn(input logic rd, input logic [3:0] a, input logic [7:0] d, input int ncyc);
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    if (!req_ready) begin chk("ready_wait", 0, 1); return; end
    req_valid = 1'b1; req_rd = rd; req_addr = a; req_data = d;
    @(posedge clk); #1 req_valid = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      tr_code[n] = {bdir, bc1}; tr_dout[n] = bus_dout; tr_rdy[n] = req_ready;
      tr_rsp[n] = rsp_valid; tr_busy[n] = busy; tr_rspd[n] = rsp_data;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  function automatic int count_code(input logic [1:0] c, input int ncyc);
    int k = 0;
    for (int n = 1; n <= ncyc; n++) if (tr_code[n] == c) k++;
    return k;
  endfunction

  function automatic int count_busy(input int ncyc);
    int k = 0;
    for (int n = 1; n <= ncyc; n++) if (tr_busy[n]) k++;
    return k;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, viol, last_acc, gap_bad, c11, c01, rsp_cnt, rsp_at;
    logic [1:0] pc, cc;
    rst_n = 1'b0; chip_clr = 1'b1;
    req_valid = 0; req_rd = 0; req_addr = 0; req_data = 0;
    req_valid2 = 0; req_rd2 = 0; req_addr2 = 0; req_data2 = 0;
    repeat (3) @(negedge clk);
    chk("rst_bdir_bc1", {bdir, bc1}, 2'b00);
    chk("rst_dout", bus_dout, 8'h00);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chip_clr = 1'b0; rst_n = 1'b1;

    // 1: write reg7 = 0x38
    run_txn(1'b0, 4'd7, 8'h38, 7);
    chk("t1_c1", tr_code[1], 2'b11); chk("t1_c2", tr_code[2], 2'b11);
    chk("t1_c3", tr_code[3], 2'b00); chk("t1_c4", tr_code[4], 2'b10);
    chk("t1_c5", tr_code[5], 2'b10); chk("t1_c6", tr_code[6], 2'b00);
    chk("t1_dout_addr", {tr_dout[1], tr_dout[2], tr_dout[3]}, 24'h070707);
    chk("t1_dout_data", {tr_dout[4], tr_dout[5]}, 16'h3838);
    chk("t1_ready6", tr_rdy[6], 1'b0);
    chk("t1_ready7", tr_rdy[7], 1'b1);
    chk("t1_busy_cnt", count_busy(7), 6);
    chk("t1_chip_reg7", chip_reg[7], 8'h38);

    // 2: write 0x5A to reg0 then read it back
    run_txn(1'b0, 4'd0, 8'h5A, 7);
    run_txn(1'b1, 4'd0, 8'hFF, 7);
    chk("t2_c1", tr_code[1], 2'b11); chk("t2_c3", tr_code[3], 2'b00);
    chk("t2_c4", tr_code[4], 2'b01); chk("t2_c5", tr_code[5], 2'b01);
    chk("t2_c6", tr_code[6], 2'b00);
    chk("t2_rd_dout", tr_dout[4], 8'h00);
    chk("t2_rsp_at6", tr_rsp[6], 1'b1);
    rsp_cnt = 0;
    for (int n = 1; n <= 7; n++) if (tr_rsp[n]) rsp_cnt++;
    chk("t2_rsp_pulses", rsp_cnt, 1);
    chk("t2_rsp_data", tr_rspd[6], 8'h5A);
    chk("t2_rsp_data_held", tr_rspd[7], 8'h5A);

    // 3: reset during the write phase
    @(negedge clk);
    req_valid = 1'b1; req_rd = 1'b0; req_addr = 4'd3; req_data = 8'h99;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t3_in_wr", {bdir, bc1}, 2'b10);
    rst_n = 1'b0; #1;
    chk("t3_rst_code", {bdir, bc1}, 2'b00);
    chk("t3_rst_dout", bus_dout, 8'h00);
    chk("t3_rst_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    chk("t3_rst_rsp", rsp_valid, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t3_reg3_kept", chip_reg[3], 8'h00);
    run_txn(1'b0, 4'd3, 8'h99, 7);
    chk("t3_after_c4", tr_code[4], 2'b10);
    chk("t3_reg3_written", chip_reg[3], 8'h99);

    // 4: back-to-back writes, req_valid held
    @(negedge clk);
    req_valid = 1'b1; req_rd = 1'b0; req_addr = 4'd1; req_data = 8'h11;
    acc = 0; viol = 0; last_acc = -7; gap_bad = 0; pc = 2'b00;
    for (int i = 0; i <= 20; i++) begin
      if (req_valid && req_ready) begin
        acc++;
        if (i - last_acc != 7) gap_bad++;
        last_acc = i;
      end
      cc = {bdir, bc1};
      if (pc != 2'b00 && cc != 2'b00 && pc != cc) viol++;
      pc = cc;
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("t4_accepts", acc, 3);
    chk("t4_spacing", gap_bad, 0);
    chk("t4_no_adjacent_active", viol, 0);
    chk("t4_reg1", chip_reg[1], 8'h11);

    // 5: repeated address (cache build shortens the second write)
    do_reset();
    run_txn(1'b0, 4'd8, 8'h21, 7);
    chk("t5_first_11", count_code(2'b11, 7), 2);
    run_txn(1'b0, 4'd8, 8'h22, 7);
`ifdef JT49_ADDR_CACHE_EN
    chk("t5_second_11", count_code(2'b11, 7), 0);
    chk("t5_second_busy", count_busy(7), 3);
    chk("t5_second_c1", tr_code[1], 2'b10);
`else
    chk("t5_second_11", count_code(2'b11, 7), 2);
    chk("t5_second_busy", count_busy(7), 6);
    chk("t5_second_c1", tr_code[1], 2'b11);
`endif
    chk("t5_reg8", chip_reg[8], 8'h22);
    do_reset();
    run_txn(1'b0, 4'd8, 8'h23, 7);
    chk("t5_after_rst_11", count_code(2'b11, 7), 2);
    chk("t5_reg8_b", chip_reg[8], 8'h23);

    // 6: HOLD=15 read of reg15
    @(negedge clk);
    chk("t6_ready", req_ready2, 1'b1);
    req_valid2 = 1'b1; req_rd2 = 1'b1; req_addr2 = 4'd15;
    @(posedge clk); #1 req_valid2 = 1'b0;
    c11 = 0; c01 = 0; rsp_cnt = 0; rsp_at = 0;
    for (int n = 1; n <= 33; n++) begin
      @(negedge clk);
      if ({bdir2, bc12} == 2'b11) c11++;
      if ({bdir2, bc12} == 2'b01) c01++;
      if (rsp_valid2) begin rsp_cnt++; rsp_at = n; end
      if (n == 32) chk("t6_ready32", req_ready2, 1'b0);
      if (n == 33) chk("t6_ready33", req_ready2, 1'b1);
    end
    chk("t6_addr_cycles", c11, 15);
    chk("t6_xfer_cycles", c01, 15);
    chk("t6_rsp_pulses", rsp_cnt, 1);
    chk("t6_rsp_at", rsp_at, 32);
    chk("t6_rsp_data", rsp_data2, 8'hF0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
